// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder with enable and valid flag.
// Define ENCODER_ERR_EN to add the registered non-one-hot err output.
module encoder_8to3 #(
    parameter int PRIORITY_MSB = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic       en,
    output logic [2:0] out,
    output logic       valid
`ifdef ENCODER_ERR_EN
    ,
    output logic       err
`endif
);

    logic [2:0] idx;
    logic       any;

    // Later assignments override earlier ones, so scan order picks the winner.
    always_comb begin
        idx = 3'd0;
        if (PRIORITY_MSB != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (in[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (in[i]) idx = 3'(i);
            end
        end
    end

    assign any = |in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= 3'd0;
            valid <= 1'b0;
        end else if (en) begin
            out   <= idx;
            valid <= any;
        end else begin
            out   <= 3'd0;
            valid <= 1'b0;
        end
    end

`ifdef ENCODER_ERR_EN
    logic onehot;

    assign onehot = any && ((in & (in - 8'd1)) == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= en && !onehot;
        end
    end
`endif

endmodule

// File: tb/tb_encoder_8to3.sv
// Directed self-checking bench for encoder_8to3.
// Checks err as well when built with ENCODER_ERR_EN.
module tb_encoder_8to3;

    localparam int PMSB = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] in;
    logic [2:0] out;
    logic       valid;
`ifdef ENCODER_ERR_EN
    logic       err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    encoder_8to3 #(
        .PRIORITY_MSB(PMSB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .en    (en),
        .out   (out),
        .valid (valid)
`ifdef ENCODER_ERR_EN
        ,
        .err   (err)
`endif
    );

    task automatic check(input string tag,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic expect_out(input string tag,
                              input logic [2:0] o,
                              input logic v,
                              input logic e);
        check({tag, ".out"}, {29'd0, out}, {29'd0, o});
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
`ifdef ENCODER_ERR_EN
        check({tag, ".err"}, {31'd0, err}, {31'd0, e});
`else
        if (e) begin end
`endif
    endtask

    task automatic drive(input logic [7:0] v, input logic e);
        @(negedge clk);
        in = v;
        en = e;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] oh_vec [8];
    logic [2:0] oh_idx [8];

    initial begin
        oh_vec = '{8'b0000_1000, 8'b0000_0010, 8'b1000_0000,
                   8'b0000_0100, 8'b0000_0001, 8'b0001_0000,
                   8'b0100_0000, 8'b0010_0000};
        oh_idx = '{3'd3, 3'd1, 3'd7, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5};

        rst = 1'b1;
        in  = 8'hFF;
        en  = 1'b1;
        #1;
        expect_out("rst_t0", 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            expect_out($sformatf("rst_hold%0d", k), 3'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            drive(8'b0010_0000, 1'b0);
            expect_out($sformatf("en_off%0d", k), 3'd0, 1'b0, 1'b0);
        end

        for (int k = 0; k < 8; k++) begin
            drive(oh_vec[k], 1'b1);
            expect_out($sformatf("onehot%0d", k), oh_idx[k], 1'b1, 1'b0);
        end

        drive(8'b0100_0010, 1'b1);
        expect_out("multi42", (PMSB != 0) ? 3'd6 : 3'd1, 1'b1, 1'b1);
        drive(8'hFF, 1'b1);
        expect_out("multiFF", (PMSB != 0) ? 3'd7 : 3'd0, 1'b1, 1'b1);
        drive(8'b0001_1000, 1'b1);
        expect_out("multi18", (PMSB != 0) ? 3'd4 : 3'd3, 1'b1, 1'b1);

        drive(8'h00, 1'b1);
        expect_out("zero", 3'd0, 1'b0, 1'b1);

        drive(8'h04, 1'b1);
        #2;
        in = 8'h80;
        en = 1'b0;
        #1;
        expect_out("between_edges", 3'd2, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            logic e;
            e = (k % 2) == 0;
            drive(8'h10, e);
            expect_out($sformatf("toggle%0d", k),
                       e ? 3'd4 : 3'd0, e, 1'b0);
        end

        drive(8'h80, 1'b1);
        expect_out("pre_rst", 3'd7, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expect_out("async_rst", 3'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        drive(8'h02, 1'b1);
        expect_out("post_rst", 3'd1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
